playback_status: RTL and testbench

- Upstream source for the 4-digit display driver.
- Keeps elapsed playback time in BCD (M:SS, 0:00–9:59) and a BCD/binary volume level.
- Generates the display select line. Select shows volume for a fixed hold time after any volume key press, then reverts to time.
- Single clock domain. All outputs are registered.

---
 rtl/playback_status.sv | 144 ++++++++++++++
 tb/tb_playback_status.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/playback_status.sv
// Playback status source for the 4-digit display: BCD elapsed time (M:SS),
// BCD/binary volume, and a display select that holds volume after key presses.
module playback_status #(
  parameter int CLK_FREQ     = 50000000,
  parameter int HOLD_SECONDS = 2,
  parameter int VOL_MAX      = 20,
  parameter int VOL_DEFAULT  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       restart,
  input  logic       vol_up,
  input  logic       vol_down,
  output logic [3:0] seconds0,
  output logic [3:0] seconds1,
  output logic [3:0] minutes0,
  output logic [3:0] volume0,
  output logic [3:0] volume1,
  output logic [6:0] volume,
  output logic       select,
  output logic       time_max
);

  localparam int HOLD_CYCLES = HOLD_SECONDS * CLK_FREQ;
  localparam int PRE_W       = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_FREQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [6:0]        VOL_TOP   = 7'(VOL_MAX);
  localparam logic [6:0]        VOL_INIT  = 7'(VOL_DEFAULT);

  typedef enum logic {
    SHOW_TIME,
    SHOW_VOLUME
  } disp_t;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  // ---------------- elapsed time ----------------
  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic             at_max;

  assign tick   = play && (prescaler == PRE_LAST);
  assign at_max = (minutes0 == 4'd9) && (seconds1 == 4'd5) && (seconds0 == 4'd9);

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      prescaler <= '0;
      seconds0  <= '0;
      seconds1  <= '0;
      minutes0  <= '0;
      time_max  <= 1'b0;
    end else if (play) begin
      if (tick) begin
        prescaler <= '0;
        if (at_max) begin
          time_max <= 1'b1;
        end else if (seconds0 == 4'd9) begin
          seconds0 <= '0;
          if (seconds1 == 4'd5) begin
            seconds1 <= '0;
            minutes0 <= minutes0 + 4'd1;
          end else begin
            seconds1 <= seconds1 + 4'd1;
          end
        end else begin
          seconds0 <= seconds0 + 4'd1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // ---------------- volume ----------------
  logic       press;
  logic [6:0] vol_next;

  assign press = vol_up ^ vol_down;

  always_comb begin
    vol_next = volume;
    if (vol_up && !vol_down && (volume != VOL_TOP))
      vol_next = volume + 7'd1;
    else if (vol_down && !vol_up && (volume != '0))
      vol_next = volume - 7'd1;
  end

  // BCD digits derive from the same next value so they never lag the binary.
  always_ff @(posedge clock) begin
    if (reset) begin
      volume             <= VOL_INIT;
      {volume1, volume0} <= to_bcd(VOL_INIT);
    end else begin
      volume             <= vol_next;
      {volume1, volume0} <= to_bcd(vol_next);
    end
  end

  // ---------------- display select FSM ----------------
  disp_t             state;
  disp_t             state_next;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;

  always_comb begin
    state_next = state;
    hold_next  = hold;
    if (press) begin
      state_next = SHOW_VOLUME;
      hold_next  = HOLD_LOAD;
    end else begin
      case (state)
        SHOW_VOLUME: begin
          if (hold == '0) state_next = SHOW_TIME;
          else            hold_next  = hold - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= SHOW_TIME;
      hold   <= '0;
      select <= 1'b0;
    end else begin
      state  <= state_next;
      hold   <= hold_next;
      select <= (state_next == SHOW_VOLUME);
    end
  end

endmodule

// File: tb/tb_playback_status.sv
// Scoreboard bench for playback_status: a behavioural model pushes expected
// outputs each cycle; they are popped and compared after the clock edge.
module tb_playback_status;

  logic       clock;
  logic       reset;
  logic       play;
  logic       restart;
  logic       vol_up;
  logic       vol_down;
  logic [3:0] seconds0;
  logic [3:0] seconds1;
  logic [3:0] minutes0;
  logic [3:0] volume0;
  logic [3:0] volume1;
  logic [6:0] volume;
  logic       select;
  logic       time_max;

  playback_status #(
    .CLK_FREQ    (4),
    .HOLD_SECONDS(2),
    .VOL_MAX     (20),
    .VOL_DEFAULT (10)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .play    (play),
    .restart (restart),
    .vol_up  (vol_up),
    .vol_down(vol_down),
    .seconds0(seconds0),
    .seconds1(seconds1),
    .minutes0(minutes0),
    .volume0 (volume0),
    .volume1 (volume1),
    .volume  (volume),
    .select  (select),
    .time_max(time_max)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // model state: total seconds, prescaler, volume, remaining select cycles
  int m_secs = 0;
  int m_pre  = 0;
  int m_vol  = 10;
  int m_sel  = 0;
  bit m_tmax = 1'b0;

  logic [28:0] exp_q[$];
  logic [28:0] dut_vec;
  logic [11:0] dut_time;

  assign dut_vec  = {minutes0, seconds1, seconds0, volume1, volume0, volume, select, time_max};
  assign dut_time = {minutes0, seconds1, seconds0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] model_vec();
    return {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
            4'(m_vol / 10), 4'(m_vol % 10), 7'(m_vol), (m_sel > 0), m_tmax};
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_secs = 0; m_pre = 0; m_tmax = 1'b0; m_vol = 10; m_sel = 0;
      return;
    end
    if (restart) begin
      m_secs = 0; m_pre = 0; m_tmax = 1'b0;
    end else if (play) begin
      if (m_pre == 3) begin
        m_pre = 0;
        if (m_secs == 599) m_tmax = 1'b1;
        else               m_secs++;
      end else begin
        m_pre++;
      end
    end
    if (vol_up != vol_down) begin
      if (vol_up && m_vol < 20) m_vol++;
      if (vol_down && m_vol > 0) m_vol--;
      m_sel = 8;
    end else if (m_sel > 0) begin
      m_sel--;
    end
  endtask

  task automatic step(input string tag);
    logic [28:0] e;
    model_edge();
    exp_q.push_back(model_vec());
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check(tag, {3'b0, dut_vec}, {3'b0, e});
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; restart = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
    run(2, "reset");
    check("rst_vals", {3'b0, dut_vec}, {3'b0, 12'h000, 4'd1, 4'd0, 7'd10, 1'b0, 1'b0});
    reset = 1'b0;

    // free-running time
    play = 1'b1;
    run(40, "run40");
    check("t40_time", {20'b0, dut_time}, {20'b0, 12'h010});
    check("t40_sel", {31'b0, select}, 32'd0);
    check("t40_vol", {25'b0, volume}, 32'd10);

    // pause and resume
    play = 1'b0; restart = 1'b1;
    step("restart");
    restart = 1'b0; play = 1'b1;
    run(6, "pre_pause");
    check("pause_start", {20'b0, dut_time}, {20'b0, 12'h001});
    play = 1'b0;
    run(10, "paused");
    check("pause_hold", {20'b0, dut_time}, {20'b0, 12'h001});
    play = 1'b1;
    step("resume1");
    check("resume_1cyc", {20'b0, dut_time}, {20'b0, 12'h001});
    step("resume2");
    check("resume_2cyc", {20'b0, dut_time}, {20'b0, 12'h002});

    // saturation at 9:59 and restart colliding with a tick
    restart = 1'b1;
    step("restart2");
    restart = 1'b0;
    run(599 * 4, "to_959");
    check("reach_959", {20'b0, dut_time}, {20'b0, 12'h959});
    run(8, "sat");
    check("sat_time", {20'b0, dut_time}, {20'b0, 12'h959});
    check("sat_tmax", {31'b0, time_max}, 32'd1);
    for (int i = 0; i < 4 && m_pre != 3; i++) step("align");
    restart = 1'b1;
    step("restart_tick");
    restart = 1'b0;
    check("rt_time", {20'b0, dut_time}, {20'b0, 12'h000});
    check("rt_tmax", {31'b0, time_max}, 32'd0);

    // volume saturation both ways
    play = 1'b0;
    vol_up = 1'b1;
    run(12, "vol_up");
    vol_up = 1'b0;
    check("vol_max", {25'b0, volume}, 32'd20);
    check("vol_max_bcd", {24'b0, volume1, volume0}, 32'h20);
    vol_down = 1'b1;
    run(21, "vol_down");
    vol_down = 1'b0;
    check("vol_min", {25'b0, volume}, 32'd0);
    vol_up = 1'b1;
    step("vol_one");
    vol_up = 1'b0;
    run(10, "expire");
    vol_up = 1'b1; vol_down = 1'b1;
    step("both");
    vol_up = 1'b0; vol_down = 1'b0;
    check("both_vol", {25'b0, volume}, 32'd1);
    check("both_sel", {31'b0, select}, 32'd0);

    // select hold: single pulse
    run(4, "idle");
    vol_up = 1'b1;
    step("pulse_T");
    vol_up = 1'b0;
    check("sel_T1", {31'b0, select}, 32'd1);
    for (int k = 2; k <= 9; k++) begin
      step("sel_single");
      check($sformatf("sel_T%0d", k), {31'b0, select}, (k <= 8) ? 32'd1 : 32'd0);
    end

    // select hold: retrigger at T+5
    run(3, "idle2");
    vol_up = 1'b1;
    step("pulse2_T");
    vol_up = 1'b0;
    for (int k = 2; k <= 14; k++) begin
      vol_down = (k == 6);
      step("sel_retrig");
      check($sformatf("rsel_T%0d", k), {31'b0, select}, (k <= 13) ? 32'd1 : 32'd0);
    end
    vol_down = 1'b0;

    // mid-operation reset
    restart = 1'b1;
    step("restart3");
    restart = 1'b0; play = 1'b1;
    run(207 * 4, "to_327");
    play = 1'b0;
    for (int i = 0; i < 20 && m_vol < 17; i++) begin
      vol_up = 1'b1;
      step("vol_to_17");
    end
    vol_up = 1'b0;
    check("pre_rst_time", {20'b0, dut_time}, {20'b0, 12'h327});
    check("pre_rst_vol", {25'b0, volume}, 32'd17);
    check("pre_rst_sel", {31'b0, select}, 32'd1);
    reset = 1'b1; play = 1'b1;
    step("mid_reset");
    reset = 1'b0; play = 1'b0;
    check("mid_rst_vals", {3'b0, dut_vec}, {3'b0, 12'h000, 4'd1, 4'd0, 7'd10, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
